// File: rtl/xrv1_retire_mp.sv
// xrv1_retire_mp: multi-port in-order retirement buffer.
//
// Completed results are parked per instruction tag. Each cycle the oldest
// contiguous run of completed entries (starting at the head tag) is retired,
// up to MAX_RET_P entries and at most NUM_WB_P register-file writes. Results
// still in flight can be forwarded to dependent operands through the bypass
// channels.
//
// Optional feature: define XRV1_RETIRE_EXC_EN to compile in exception
// handling. An excepting entry retires alone at the head, pulses exc_vld_o and
// parks the block in HALT until flush_i.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   fu_done_i/exc_i     per-FU completion valid / result excepted
//   fu_itag_i           per-FU completing tag (packed, ITAG_WIDTH_P each)
//   fu_wb_data_i        per-FU result data (packed, DATA_WIDTH_P each)
//   issue_itag_i        next tag to be issued (tail of the window)
//   iqueue_vld_i        per-tag: entry allocated
//   iqueue_rd_vld_i     per-tag: entry writes a destination register
//   iqueue_rd_addr_i    per-tag destination register (packed)
//   retire_rdy_i        retirement permitted this cycle
//   flush_i             discard all outstanding entries
//   retire_itag_o       head tag
//   retire_cnt_o        entries retired on the previous clock edge
//   wb_vld_o/rd_addr_o/data_o  registered RF write lanes, program order
//   exc_vld_o/itag_o    exception retired (one-cycle pulse) and its tag
//   rs_conflict_i       per channel, per-tag: older producer of the operand
//   rs_conflict_o       operand must stall
//   rs_byp_en_o/data_o  operand forwarded from a completed producer
module xrv1_retire_mp #(
    parameter int unsigned DATA_WIDTH_P    = 32,
    parameter int unsigned ITAG_WIDTH_P    = 3,
    parameter int unsigned NUM_FU_P        = 6,
    parameter int unsigned NUM_RS_P        = 2,
    parameter int unsigned NUM_WB_P        = 2,
    parameter int unsigned MAX_RET_P       = 4,
    parameter int unsigned RF_ADDR_WIDTH_P = 5,
    localparam int unsigned Depth          = 1 << ITAG_WIDTH_P,
    localparam int unsigned CntW           = $clog2(MAX_RET_P + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_FU_P-1:0]                 fu_done_i,
    input  logic [NUM_FU_P-1:0]                 fu_exc_i,
    input  logic [NUM_FU_P*ITAG_WIDTH_P-1:0]    fu_itag_i,
    input  logic [NUM_FU_P*DATA_WIDTH_P-1:0]    fu_wb_data_i,
    input  logic [ITAG_WIDTH_P-1:0]             issue_itag_i,
    input  logic [Depth-1:0]                    iqueue_vld_i,
    input  logic [Depth-1:0]                    iqueue_rd_vld_i,
    input  logic [Depth*RF_ADDR_WIDTH_P-1:0]    iqueue_rd_addr_i,
    input  logic                                retire_rdy_i,
    input  logic                                flush_i,
    output logic [ITAG_WIDTH_P-1:0]             retire_itag_o,
    output logic [CntW-1:0]                     retire_cnt_o,
    output logic [NUM_WB_P-1:0]                 wb_vld_o,
    output logic [NUM_WB_P*RF_ADDR_WIDTH_P-1:0] wb_rd_addr_o,
    output logic [NUM_WB_P*DATA_WIDTH_P-1:0]    wb_data_o,
    output logic                                exc_vld_o,
    output logic [ITAG_WIDTH_P-1:0]             exc_itag_o,
    input  logic [NUM_RS_P*Depth-1:0]           rs_conflict_i,
    output logic [NUM_RS_P-1:0]                 rs_conflict_o,
    output logic [NUM_RS_P-1:0]                 rs_byp_en_o,
    output logic [NUM_RS_P*DATA_WIDTH_P-1:0]    rs_byp_data_o
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e                           state_q, state_d;
    logic [Depth-1:0]                 vld_q, vld_n, vld_d;
    logic [Depth-1:0]                 exc_q, exc_n, exc_d;
    logic [Depth-1:0]                 ret_mask;
    logic [DATA_WIDTH_P-1:0]          data_q [Depth];
    logic [DATA_WIDTH_P-1:0]          data_n [Depth];
    logic [ITAG_WIDTH_P-1:0]          head_q, head_d, occ;
    logic [CntW-1:0]                  cnt_d, cnt_q;
    logic [NUM_WB_P-1:0]              wb_vld_d, wb_vld_q;
    logic [NUM_WB_P*RF_ADDR_WIDTH_P-1:0] wb_addr_d, wb_addr_q;
    logic [NUM_WB_P*DATA_WIDTH_P-1:0] wb_data_d, wb_data_q;
    logic                             exc_hit, exc_vld_q;
    logic [ITAG_WIDTH_P-1:0]          exc_itag_d, exc_itag_q;

`ifndef XRV1_RETIRE_EXC_EN
    logic unused_fu_exc;
    assign unused_fu_exc = ^fu_exc_i;
`endif

    // Occupied window is [head, issue); equal pointers mean empty.
    assign occ = issue_itag_i - head_q;

    // Buffer as it will look after this cycle's completions; higher port wins.
    always_comb begin
        vld_n  = vld_q;
        exc_n  = exc_q;
        data_n = data_q;
        for (int k = 0; k < NUM_FU_P; k++) begin
            if (fu_done_i[k]) begin
                vld_n[fu_itag_i[k*ITAG_WIDTH_P +: ITAG_WIDTH_P]]  = 1'b1;
                data_n[fu_itag_i[k*ITAG_WIDTH_P +: ITAG_WIDTH_P]] =
                    fu_wb_data_i[k*DATA_WIDTH_P +: DATA_WIDTH_P];
`ifdef XRV1_RETIRE_EXC_EN
                exc_n[fu_itag_i[k*ITAG_WIDTH_P +: ITAG_WIDTH_P]]  = fu_exc_i[k];
`else
                exc_n[fu_itag_i[k*ITAG_WIDTH_P +: ITAG_WIDTH_P]]  = 1'b0;
`endif
            end
        end
    end

    // Retirement scan from the head over the post-completion buffer.
    always_comb begin
        logic                    stop;
        int                      n_ret;
        int                      n_wb;
        logic [ITAG_WIDTH_P-1:0] tag;
        stop      = 1'b0;
        n_ret     = 0;
        n_wb      = 0;
        tag       = '0;
        ret_mask  = '0;
        wb_vld_d  = '0;
        wb_addr_d = '0;
        wb_data_d = '0;
        exc_hit   = 1'b0;
        if (state_q == StRun && retire_rdy_i && !flush_i) begin
            for (int i = 0; i < MAX_RET_P; i++) begin
                tag = head_q + ITAG_WIDTH_P'(i);
                if (!stop) begin
                    if (i >= int'(occ) || !iqueue_vld_i[tag] || !vld_n[tag]) begin
                        stop = 1'b1;
                    end
`ifdef XRV1_RETIRE_EXC_EN
                    else if (exc_n[tag]) begin
                        // Excepting entry retires only when it is the oldest.
                        stop = 1'b1;
                        if (i == 0) begin
                            exc_hit       = 1'b1;
                            ret_mask[tag] = 1'b1;
                            n_ret         = 1;
                        end
                    end
`endif
                    else if (iqueue_rd_vld_i[tag] && n_wb == int'(NUM_WB_P)) begin
                        stop = 1'b1;
                    end else begin
                        ret_mask[tag] = 1'b1;
                        n_ret++;
                        if (iqueue_rd_vld_i[tag]) begin
                            wb_vld_d[n_wb] = 1'b1;
                            wb_addr_d[n_wb*RF_ADDR_WIDTH_P +: RF_ADDR_WIDTH_P] =
                                iqueue_rd_addr_i[int'(tag)*RF_ADDR_WIDTH_P +: RF_ADDR_WIDTH_P];
                            wb_data_d[n_wb*DATA_WIDTH_P +: DATA_WIDTH_P] = data_n[tag];
                            n_wb++;
                        end
                    end
                end
            end
        end
        cnt_d = CntW'(n_ret);
    end

    always_comb begin
        vld_d      = flush_i ? '0 : (vld_n & ~ret_mask);
        exc_d      = flush_i ? '0 : (exc_n & ~ret_mask);
        head_d     = flush_i ? issue_itag_i : head_q + ITAG_WIDTH_P'(cnt_d);
        exc_itag_d = exc_hit ? head_q : '0;
        state_d    = state_q;
`ifdef XRV1_RETIRE_EXC_EN
        if (exc_hit) state_d = StHalt;
`endif
        if (flush_i) state_d = StRun;
    end

    // Bypass: youngest older producer decides between forward and stall.
    always_comb begin
        logic                    found;
        logic [ITAG_WIDTH_P-1:0] byp_tag;
        rs_conflict_o = '0;
        rs_byp_en_o   = '0;
        rs_byp_data_o = '0;
        found         = 1'b0;
        byp_tag       = '0;
        for (int j = 0; j < NUM_RS_P; j++) begin
            found = 1'b0;
            for (int i = 0; i < Depth; i++) begin
                byp_tag = issue_itag_i - ITAG_WIDTH_P'(i + 1);
                if (!found && i < int'(occ) && rs_conflict_i[j*Depth + int'(byp_tag)]) begin
                    found = 1'b1;
                    if (vld_n[byp_tag]) begin
                        rs_byp_en_o[j] = 1'b1;
                        rs_byp_data_o[j*DATA_WIDTH_P +: DATA_WIDTH_P] = data_n[byp_tag];
                    end else begin
                        rs_conflict_o[j] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StRun;
            vld_q      <= '0;
            exc_q      <= '0;
            head_q     <= '0;
            cnt_q      <= '0;
            wb_vld_q   <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            exc_vld_q  <= 1'b0;
            exc_itag_q <= '0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            exc_q      <= exc_d;
            head_q     <= head_d;
            cnt_q      <= cnt_d;
            wb_vld_q   <= wb_vld_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            exc_vld_q  <= exc_hit;
            exc_itag_q <= exc_itag_d;
        end
    end

    // Payload storage is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        for (int t = 0; t < Depth; t++) data_q[t] <= data_n[t];
    end

    assign retire_itag_o = head_q;
    assign retire_cnt_o  = cnt_q;
    assign wb_vld_o      = wb_vld_q;
    assign wb_rd_addr_o  = wb_addr_q;
    assign wb_data_o     = wb_data_q;
    assign exc_vld_o     = exc_vld_q;
    assign exc_itag_o    = exc_itag_q;

endmodule

// File: tb/tb_xrv1_retire_mp.sv
// Bench for xrv1_retire_mp: directed scenarios plus random traffic, all checked
// against a tag-window reference model through scoreboard queues.
module tb_xrv1_retire_mp;
    localparam int DW = 32, IW = 3, D = 8, NF = 6, NR = 2, NW = 2, MR = 4, AW = 5;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic [NF-1:0]     fu_done_i, fu_exc_i;
    logic [NF*IW-1:0]  fu_itag_i;
    logic [NF*DW-1:0]  fu_wb_data_i;
    logic [IW-1:0]     issue_itag_i;
    logic [D-1:0]      iqueue_vld_i, iqueue_rd_vld_i;
    logic [D*AW-1:0]   iqueue_rd_addr_i;
    logic              retire_rdy_i, flush_i;
    logic [IW-1:0]     retire_itag_o;
    logic [2:0]        retire_cnt_o;
    logic [NW-1:0]     wb_vld_o;
    logic [NW*AW-1:0]  wb_rd_addr_o;
    logic [NW*DW-1:0]  wb_data_o;
    logic              exc_vld_o;
    logic [IW-1:0]     exc_itag_o;
    logic [NR*D-1:0]   rs_conflict_i;
    logic [NR-1:0]     rs_conflict_o, rs_byp_en_o;
    logic [NR*DW-1:0]  rs_byp_data_o;

    xrv1_retire_mp dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fu_done_i(fu_done_i), .fu_exc_i(fu_exc_i), .fu_itag_i(fu_itag_i),
        .fu_wb_data_i(fu_wb_data_i), .issue_itag_i(issue_itag_i),
        .iqueue_vld_i(iqueue_vld_i), .iqueue_rd_vld_i(iqueue_rd_vld_i),
        .iqueue_rd_addr_i(iqueue_rd_addr_i), .retire_rdy_i(retire_rdy_i),
        .flush_i(flush_i), .retire_itag_o(retire_itag_o), .retire_cnt_o(retire_cnt_o),
        .wb_vld_o(wb_vld_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
        .exc_vld_o(exc_vld_o), .exc_itag_o(exc_itag_o), .rs_conflict_i(rs_conflict_i),
        .rs_conflict_o(rs_conflict_o), .rs_byp_en_o(rs_byp_en_o),
        .rs_byp_data_o(rs_byp_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]       cnt;
        logic [NW-1:0]    wbv;
        logic [NW*AW-1:0] addr;
        logic [NW*DW-1:0] data;
        logic             ev;
        logic [IW-1:0]    etag;
        logic [IW-1:0]    head;
    } exp_t;
    typedef struct {
        logic [NR-1:0]    conf;
        logic [NR-1:0]    en;
        logic [NR*DW-1:0] data;
    } byp_t;

    exp_t exp_q[$];
    byp_t byp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: tag window [m_head, tail) and per-tag completion state.
    int           m_head = 0, tail = 0;
    bit           m_halt = 0;
    bit           m_vld[D], m_exc[D];
    logic [31:0]  m_data[D];
    bit           alloc_rd[D];
    logic [AW-1:0] alloc_addr[D];

    // Stimulus for the next cycle.
    bit           s_done[NF], s_exc[NF];
    logic [IW-1:0] s_tag[NF];
    logic [31:0]  s_data[NF];
    bit           s_rdy, s_flush;
    bit           s_conf[NR][D];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int occ_f();
        return (tail - m_head + D) % D;
    endfunction

    task automatic clear_stim();
        for (int k = 0; k < NF; k++) begin
            s_done[k] = 0; s_exc[k] = 0; s_tag[k] = '0; s_data[k] = '0;
        end
        for (int j = 0; j < NR; j++) for (int t = 0; t < D; t++) s_conf[j][t] = 0;
        s_rdy = 1; s_flush = 0;
    endtask

    task automatic alloc(int t, bit rd, logic [AW-1:0] a);
        alloc_rd[t] = rd; alloc_addr[t] = a;
    endtask

    task automatic comp(int k, int t, logic [31:0] d);
        s_done[k] = 1; s_tag[k] = 3'(t); s_data[k] = d;
    endtask

    task automatic apply();
        int occ;
        occ = occ_f();
        for (int k = 0; k < NF; k++) begin
            fu_done_i[k] = s_done[k];
            fu_exc_i[k]  = s_exc[k];
            fu_itag_i[k*IW +: IW] = s_tag[k];
            fu_wb_data_i[k*DW +: DW] = s_data[k];
        end
        issue_itag_i = 3'(tail);
        for (int t = 0; t < D; t++) begin
            iqueue_vld_i[t]    = ((t - m_head + D) % D) < occ;
            iqueue_rd_vld_i[t] = alloc_rd[t];
            iqueue_rd_addr_i[t*AW +: AW] = alloc_addr[t];
            for (int j = 0; j < NR; j++) rs_conflict_i[j*D + t] = s_conf[j][t];
        end
        retire_rdy_i = s_rdy;
        flush_i      = s_flush;
    endtask

    // Apply stimulus now and push the predicted responses.
    task automatic step_body();
        bit          nv[D], ne[D];
        logic [31:0] nd[D];
        int          occ, youngest, n, wbn, t;
        bit          f;
        exp_t        e;
        byp_t        b;
        apply();
        occ = occ_f();
        for (int tt = 0; tt < D; tt++) begin
            nv[tt] = m_vld[tt]; ne[tt] = m_exc[tt]; nd[tt] = m_data[tt]; f = 0;
            for (int k = NF - 1; k >= 0; k--) begin
                if (!f && s_done[k] && int'(s_tag[k]) == tt) begin
                    f = 1; nv[tt] = 1; nd[tt] = s_data[k];
`ifdef XRV1_RETIRE_EXC_EN
                    ne[tt] = s_exc[k];
`endif
                end
            end
        end
        b.conf = '0; b.en = '0; b.data = '0;
        for (int j = 0; j < NR; j++) begin
            youngest = -1;
            for (int off = 0; off < occ; off++)
                if (s_conf[j][(m_head + off) % D]) youngest = (m_head + off) % D;
            if (youngest >= 0) begin
                if (nv[youngest]) begin
                    b.en[j] = 1; b.data[j*DW +: DW] = nd[youngest];
                end else begin
                    b.conf[j] = 1;
                end
            end
        end
        byp_q.push_back(b);
        e.cnt = '0; e.wbv = '0; e.addr = '0; e.data = '0; e.ev = 0; e.etag = '0;
        if (!m_halt && s_rdy && !s_flush) begin
            n = 0; wbn = 0;
            for (int off = 0; off < occ && off < MR; off++) begin
                t = (m_head + off) % D;
                if (!nv[t]) break;
`ifdef XRV1_RETIRE_EXC_EN
                if (ne[t]) begin
                    if (off == 0) begin
                        e.ev = 1; e.etag = 3'(t); n = 1; nv[t] = 0; ne[t] = 0; m_halt = 1;
                    end
                    break;
                end
`endif
                if (alloc_rd[t]) begin
                    if (wbn == NW) break;
                    e.wbv[wbn] = 1;
                    e.addr[wbn*AW +: AW] = alloc_addr[t];
                    e.data[wbn*DW +: DW] = nd[t];
                    wbn++;
                end
                nv[t] = 0;
                n++;
            end
            e.cnt  = 3'(n);
            m_head = (m_head + n) % D;
        end
        if (s_flush) begin
            for (int tt = 0; tt < D; tt++) begin nv[tt] = 0; ne[tt] = 0; end
            m_head = tail; m_halt = 0;
        end
        for (int tt = 0; tt < D; tt++) begin
            m_vld[tt] = nv[tt]; m_exc[tt] = ne[tt]; m_data[tt] = nd[tt];
        end
        e.head = 3'(m_head);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk_i);
        step_body();
    endtask

    task automatic model_reset();
        for (int t = 0; t < D; t++) begin m_vld[t] = 0; m_exc[t] = 0; m_data[t] = '0; end
        m_head = 0; tail = 0; m_halt = 0;
    endtask

    task automatic chk_zero_outputs(string tagname);
        chk({tagname, "_cnt"}, retire_cnt_o, 0);
        chk({tagname, "_wb_vld"}, wb_vld_o, 0);
        chk({tagname, "_wb_addr"}, wb_rd_addr_o, 0);
        chk({tagname, "_wb_data"}, wb_data_o, 0);
        chk({tagname, "_exc_vld"}, exc_vld_o, 0);
        chk({tagname, "_exc_itag"}, exc_itag_o, 0);
        chk({tagname, "_head"}, retire_itag_o, 0);
    endtask

    // Monitor: bypass mid-cycle, registered outputs just after the edge.
    initial begin
        byp_t b;
        exp_t e;
        forever begin
            @(negedge clk_i); #3;
            if (byp_q.size() > 0) begin
                b = byp_q.pop_front();
                chk("rs_conflict", rs_conflict_o, b.conf);
                chk("rs_byp_en", rs_byp_en_o, b.en);
                for (int j = 0; j < NR; j++)
                    if (b.en[j]) chk("rs_byp_data", rs_byp_data_o[j*DW +: DW], b.data[j*DW +: DW]);
            end
            @(posedge clk_i); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("retire_cnt", retire_cnt_o, e.cnt);
                chk("wb_vld", wb_vld_o, e.wbv);
                chk("wb_rd_addr", wb_rd_addr_o, e.addr);
                chk("wb_data", wb_data_o, e.data);
                chk("exc_vld", exc_vld_o, e.ev);
                chk("exc_itag", exc_itag_o, e.etag);
                chk("retire_itag", retire_itag_o, e.head);
            end
        end
    end

    initial begin
        int occ;
        for (int t = 0; t < D; t++) alloc(t, 0, '0);
        model_reset();
        clear_stim();
        apply();
        #1 rst_ni = 1'b0;
        #2 chk_zero_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Move head to 6 with a flush, then retire across the wrap point.
        clear_stim(); tail = 6; s_flush = 1; step();
        clear_stim();
        alloc(6, 0, '0); alloc(7, 0, '0); alloc(0, 0, '0); tail = 1;
        comp(0, 6, 32'h66); comp(1, 7, 32'h77); comp(2, 0, 32'h80);
        step();

        // Four rd-writing completions in one cycle drain two per cycle.
        clear_stim();
        for (int t = 1; t <= 4; t++) alloc(t, 1, 5'(t + 10));
        tail = 5;
        for (int k = 0; k < 4; k++) comp(k, 1 + k, 32'h100 + k);
        comp(4, 1, 32'hABC);  // same-tag collision, higher port wins
        step();
        clear_stim(); step();
        clear_stim(); step();

        // Out-of-order completions wait for the oldest entry.
        clear_stim();
        alloc(5, 0, '0); alloc(6, 0, '0); alloc(7, 0, '0); tail = 0;
        comp(0, 6, 32'h600); comp(1, 7, 32'h700);
        step();
        clear_stim(); comp(0, 5, 32'h500); step();

        // Bypass: producers 1 and 3, tag 3 youngest.
        clear_stim();
        for (int t = 0; t < 4; t++) alloc(t, 1, 5'(t + 20));
        tail = 4;
        s_rdy = 0; s_conf[0][1] = 1; s_conf[0][3] = 1; s_conf[1][5] = 1;
        step();
        clear_stim(); s_rdy = 0; s_conf[0][1] = 1; s_conf[0][3] = 1;
        comp(2, 3, 32'hDEAD); step();
        clear_stim(); s_rdy = 0; s_conf[0][1] = 1; s_conf[0][3] = 1; s_conf[1][1] = 1;
        comp(0, 1, 32'h1111); step();

        // Build several valid entries, retire two, then reset mid-flight.
        clear_stim();
        alloc(4, 1, 5'd24); alloc(5, 1, 5'd25); tail = 6;
        s_rdy = 0; comp(0, 0, 32'hA0); comp(1, 2, 32'hA2); comp(2, 4, 32'hA4);
        comp(3, 5, 32'hA5);
        step();
        clear_stim(); step();
        @(negedge clk_i); #2;
        rst_ni = 1'b0;
        #1 chk_zero_outputs("midreset");
        model_reset();
        clear_stim();
        apply();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int t = 0; t < 6; t++) alloc(t, 1, 5'(t));
        tail = 6;
        clear_stim();
        step_body();
        clear_stim(); step();

`ifdef XRV1_RETIRE_EXC_EN
        clear_stim(); comp(0, 0, 32'hE0); comp(1, 1, 32'hE1); step();
        clear_stim(); comp(0, 2, 32'hE2); s_exc[0] = 1; comp(1, 3, 32'hE3); step();
        clear_stim(); comp(0, 4, 32'hE4); comp(1, 5, 32'hE5); step();
        clear_stim(); step();
        clear_stim(); s_flush = 1; step();
        clear_stim(); step();
`endif

        for (int c = 0; c < 3000; c++) begin
            clear_stim();
            for (int a = 0; a < 2; a++) begin
                if (occ_f() < D - 1 && $urandom_range(0, 1) == 1) begin
                    alloc(tail, $urandom_range(0, 3) != 0, 5'($urandom));
                    tail = (tail + 1) % D;
                end
            end
            occ = occ_f();
            for (int k = 0; k < NF; k++) begin
                if (occ > 0 && $urandom_range(0, 2) == 0)
                    comp(k, (m_head + $urandom_range(0, occ - 1)) % D, $urandom);
                s_exc[k] = $urandom_range(0, 15) == 0;
            end
            s_rdy   = $urandom_range(0, 4) != 0;
            s_flush = $urandom_range(0, 29) == 0;
            for (int j = 0; j < NR; j++)
                for (int t = 0; t < D; t++) s_conf[j][t] = $urandom_range(0, 3) == 0;
            step();
        end

        clear_stim(); step();
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0 || byp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q.size(), byp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
